// File: rtl/pole_pkg.sv
// rtl/pole_pkg.sv - shared lever state encoding and frame indices for the pole lever sprite
package pole_pkg;

  typedef enum logic [1:0] {
    REST_LEFT  = 2'd0,
    SWING_R    = 2'd1,
    REST_RIGHT = 2'd2,
    SWING_L    = 2'd3
  } lever_state_t;

  localparam logic [1:0] FRAME_LEFT  = 2'd0;
  localparam logic [1:0] FRAME_MID   = 2'd1;
  localparam logic [1:0] FRAME_RIGHT = 2'd2;

  // Both swing directions show the same MID artwork.
  function automatic logic [1:0] frame_of(input lever_state_t s);
    case (s)
      REST_LEFT:  frame_of = FRAME_LEFT;
      REST_RIGHT: frame_of = FRAME_RIGHT;
      default:    frame_of = FRAME_MID;
    endcase
  endfunction

endpackage

// File: rtl/pole_lever_fsm.sv
// rtl/pole_lever_fsm.sv - lever state machine timed by vsync rising edges
module pole_lever_fsm
  import pole_pkg::*;
#(
  parameter int HOLD_FRAMES = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_frame_clk,
  input  logic         i_push_left,
  input  logic         i_push_right,
  output lever_state_t o_state
);

  localparam logic [7:0] LAST_CNT = 8'(HOLD_FRAMES - 1);

  lever_state_t r_state, w_state_n;
  logic [7:0]   r_cnt, w_cnt_n;
  logic         r_frame_prev;
  logic         w_tick;
  logic         w_go_left, w_go_right;

  // frame_prev resets high so a vsync already high at reset release is not a tick.
  assign w_tick     = i_frame_clk & ~r_frame_prev;
  assign w_go_left  = i_push_left & ~i_push_right;
  assign w_go_right = i_push_right & ~i_push_left;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= REST_LEFT;
      r_cnt        <= 8'd0;
      r_frame_prev <= 1'b1;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_frame_prev <= i_frame_clk;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      REST_LEFT: begin
        if (w_go_right) begin
          w_state_n = SWING_R;
          w_cnt_n   = 8'd0;
        end
      end
      REST_RIGHT: begin
        if (w_go_left) begin
          w_state_n = SWING_L;
          w_cnt_n   = 8'd0;
        end
      end
      SWING_R, SWING_L: begin
        if (w_tick) begin
          w_cnt_n = r_cnt + 8'd1;
          if (r_cnt == LAST_CNT) begin
            w_state_n = (r_state == SWING_R) ? REST_RIGHT : REST_LEFT;
          end
        end
      end
      default: begin
        w_state_n = REST_LEFT;
        w_cnt_n   = 8'd0;
      end
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/pole_lever.sv
// rtl/pole_lever.sv - two-position lever sprite: hit test, unified frame ROM address, settled state
module pole_lever
  import pole_pkg::*;
#(
  parameter int POS_X       = 140,
  parameter int POS_Y       = 310,
  parameter int SPR_W       = 24,
  parameter int SPR_H       = 24,
  parameter int HOLD_FRAMES = 8,
  parameter int ADDR_W      = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              push_left,
  input  logic              push_right,
  output logic              is_pole,
  output logic [ADDR_W-1:0] pole_address,
  output logic              lever_right,
  output logic              busy
);

  localparam logic [9:0]        X_LO       = 10'(POS_X);
  localparam logic [9:0]        X_HI       = 10'(POS_X + SPR_W);
  localparam logic [9:0]        Y_LO       = 10'(POS_Y);
  localparam logic [9:0]        Y_HI       = 10'(POS_Y + SPR_H);
  localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] ROW_PITCH  = ADDR_W'(SPR_W);

  lever_state_t      w_state;
  logic              w_hit;
  logic [9:0]        w_dx, w_dy;
  logic [ADDR_W-1:0] w_addr;
  logic              r_is_pole;
  logic [ADDR_W-1:0] r_address;

  pole_lever_fsm #(
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_fsm (
    .i_clk        (Clk),
    .i_reset      (Reset),
    .i_frame_clk  (frame_clk),
    .i_push_left  (push_left),
    .i_push_right (push_right),
    .o_state      (w_state)
  );

  assign w_hit = (DrawX >= X_LO) && (DrawX < X_HI) &&
                 (DrawY >= Y_LO) && (DrawY < Y_HI);
  assign w_dx  = DrawX - X_LO;
  assign w_dy  = DrawY - Y_LO;

  // Offsets are meaningless outside the window, so the address is zeroed there.
  always_comb begin
    w_addr = '0;
    if (w_hit) begin
      w_addr = ADDR_W'(frame_of(w_state)) * FRAME_SIZE
             + ADDR_W'(w_dx)
             + ADDR_W'(w_dy) * ROW_PITCH;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_is_pole <= 1'b0;
      r_address <= '0;
    end else begin
      r_is_pole <= w_hit;
      r_address <= w_addr;
    end
  end

  assign is_pole      = r_is_pole;
  assign pole_address = r_address;
  assign lever_right  = (w_state == REST_RIGHT);
  assign busy         = (w_state == SWING_R) || (w_state == SWING_L);

endmodule

// File: tb/tb_pole_lever.sv
// tb/tb_pole_lever.sv - directed self-checking bench for pole_lever
`timescale 1ns/1ps
module tb_pole_lever;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  DrawX, DrawY;
  logic        push_left, push_right;
  logic        is_pole;
  logic [10:0] pole_address;
  logic        lever_right;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  pole_lever dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .push_left    (push_left),
    .push_right   (push_right),
    .is_pole      (is_pole),
    .pole_address (pole_address),
    .lever_right  (lever_right),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input int x, input int y, input int hit, input int addr);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    chk({tag, "_hit"}, int'(is_pole), hit);
    chk({tag, "_addr"}, int'(pole_address), addr);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; DrawX = 10'd140; DrawY = 10'd310;
    push_left = 1'b0; push_right = 1'b0;
    step(); step();
    chk("rst_is_pole", int'(is_pole), 0);
    chk("rst_addr", int'(pole_address), 0);
    chk("rst_lever_right", int'(lever_right), 0);
    chk("rst_busy", int'(busy), 0);
    Reset = 1'b0;

    chk_pix("px_topleft", 140, 310, 1, 0);
    chk_pix("px_botright", 163, 333, 1, 575);
    chk_pix("px_x_out", 164, 333, 0, 0);
    chk_pix("px_y_out", 140, 309, 0, 0);
    chk_pix("px_topright", 163, 310, 1, 23);
    chk_pix("px_botleft", 140, 333, 1, 552);
    chk_pix("px_y_end", 150, 334, 0, 0);

    push_left = 1'b1; push_right = 1'b1; step();
    push_left = 1'b0; push_right = 1'b0; step();
    chk("both_busy", int'(busy), 0);
    chk("both_right", int'(lever_right), 0);
    push_left = 1'b1; step(); push_left = 1'b0; step();
    chk("left_in_left_busy", int'(busy), 0);

    push_right = 1'b1; step(); push_right = 1'b0;
    chk("swing_r_busy", int'(busy), 1);
    chk("swing_r_not_right", int'(lever_right), 0);
    chk_pix("swing_r_mid", 140, 310, 1, 576);
    push_left = 1'b1; step(); push_left = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("swing_r_7ticks_busy", int'(busy), 1);
    tick();
    chk("swing_r_done_busy", int'(busy), 0);
    chk("swing_r_done_right", int'(lever_right), 1);
    chk("swing_r_done_addr", int'(pole_address), 1152);
    chk_pix("right_frame", 141, 311, 1, 1177);

    push_right = 1'b1; step(); push_right = 1'b0; step();
    chk("right_in_right_busy", int'(busy), 0);

    push_left = 1'b1; frame_clk = 1'b1; step();
    push_left = 1'b0; frame_clk = 1'b0; step();
    chk("coinc_busy", int'(busy), 1);
    chk("coinc_addr", int'(pole_address), 601);
    for (int i = 0; i < 7; i++) tick();
    chk("coinc_7ticks_busy", int'(busy), 1);
    tick();
    chk("coinc_done_busy", int'(busy), 0);
    chk("coinc_done_right", int'(lever_right), 0);
    chk("coinc_done_addr", int'(pole_address), 25);

    push_right = 1'b1; step(); push_right = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("reswing_right", int'(lever_right), 1);
    push_left = 1'b1; step(); push_left = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("swing_l_busy", int'(busy), 1);
    Reset = 1'b1; frame_clk = 1'b1; step();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_right", int'(lever_right), 0);
    chk("midrst_hit", int'(is_pole), 0);
    chk("midrst_addr", int'(pole_address), 0);
    Reset = 1'b0; step();
    chk("post_rst_right", int'(lever_right), 0);
    chk("post_rst_addr", int'(pole_address), 25);

    push_right = 1'b1; step(); push_right = 1'b0; step();
    frame_clk = 1'b0; step();
    for (int i = 0; i < 7; i++) tick();
    chk("held_high_7ticks_busy", int'(busy), 1);
    tick();
    chk("held_high_done_busy", int'(busy), 0);
    chk("held_high_done_right", int'(lever_right), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
